// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds, synchronous flush
// and selectable standard (1-cycle registered read) or first-word-fall-through read mode.
module sync_fifo_flags #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rdata,
    output logic                       rvalid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH = $clog2(DEPTH+1);
    localparam logic [PTR_WIDTH:0] PTR_ONE = 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [PTR_WIDTH:0]   r_wptr;
    logic [PTR_WIDTH:0]   r_rptr;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_full;
    logic                 r_empty;
    logic                 r_af;
    logic                 r_ae;
    logic                 r_ovf;
    logic                 r_unf;
    logic                 r_rvalid;
    logic [WIDTH-1:0]     r_rdata;

    logic                 w_rd_acc;
    logic                 w_wr_acc;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic [PTR_WIDTH-1:0] w_waddr;
    logic [PTR_WIDTH-1:0] w_raddr;

    assign w_waddr = r_wptr[PTR_WIDTH-1:0];
    assign w_raddr = r_rptr[PTR_WIDTH-1:0];

    // A full FIFO still takes a write when a read frees a slot on the same edge.
    always_comb begin
        w_rd_acc   = rd_en && !r_empty && !clear;
        w_wr_acc   = wr_en && (!r_full || w_rd_acc) && !clear;
        w_cnt_next = r_count;
        if (clear) begin
            w_cnt_next = '0;
        end else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10:   w_cnt_next = r_count + CNT_ONE;
                2'b01:   w_cnt_next = r_count - CNT_ONE;
                default: w_cnt_next = r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[w_waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_ovf   <= wr_en && !w_wr_acc && !clear;
            r_unf   <= rd_en && !w_rd_acc && !clear;
            r_count <= w_cnt_next;
            r_full  <= (w_cnt_next == CNT_WIDTH'(DEPTH));
            r_empty <= (w_cnt_next == '0);
            r_af    <= (w_cnt_next >= CNT_WIDTH'(AF_THRESH));
            r_ae    <= (w_cnt_next <= CNT_WIDTH'(AE_THRESH));
            if (clear) begin
                r_wptr   <= '0;
                r_rptr   <= '0;
                r_rvalid <= 1'b0;
            end else begin
                if (w_wr_acc) r_wptr <= r_wptr + PTR_ONE;
                if (w_rd_acc) r_rptr <= r_rptr + PTR_ONE;
                r_rvalid <= w_rd_acc;
                if (w_rd_acc) r_rdata <= r_mem[w_raddr];
            end
        end
    end

    // In FWFT mode the head entry is shown directly; zero while empty so reset/flush read as 0.
    assign rdata        = (FWFT != 0) ? (r_empty ? '0 : r_mem[w_raddr]) : r_rdata;
    assign rvalid       = (FWFT != 0) ? !r_empty : r_rvalid;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;
endmodule
